// File: rtl/fir_mac_sequencer_if.sv
// Sample stream, result stream and coefficient-write port of the FIR MAC sequencer.
// The master side is the producer of samples and coefficients; the slave side is the engine.
interface fir_mac_sequencer_if #(
    parameter int unsigned N      = 16,
    parameter int unsigned N_TAPS = 4
);
    localparam int unsigned TW    = $clog2(N_TAPS);
    localparam int unsigned OUT_W = 2 * N + TW;

    logic                    coef_we;
    logic [TW-1:0]           coef_addr;
    logic signed [N-1:0]     coef_data;
    logic                    coef_err;

    logic                    s_valid;
    logic                    s_ready;
    logic signed [N-1:0]     s_sample;

    logic                    m_valid;
    logic                    m_ready;
    logic signed [OUT_W-1:0] m_out;

    modport master (
        output coef_we, coef_addr, coef_data, s_valid, s_sample, m_ready,
        input  coef_err, s_ready, m_valid, m_out
    );

    modport slave (
        input  coef_we, coef_addr, coef_data, s_valid, s_sample, m_ready,
        output coef_err, s_ready, m_valid, m_out
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR engine: one shared signed N x N multiplier walks the taps one per
// cycle, between a valid/ready sample source and a valid/ready result consumer.
module fir_mac_sequencer #(
    parameter int unsigned N      = 16,
    parameter int unsigned N_TAPS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    fir_mac_sequencer_if.slave   bus,
    output logic                 shift,
    output logic                 busy
);
    localparam int unsigned TW    = $clog2(N_TAPS);
    localparam int unsigned OUT_W = 2 * N + TW;
    localparam int unsigned PW    = 2 * N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic signed [N-1:0]     hist [N_TAPS];
    logic signed [N-1:0]     coef [N_TAPS];
    logic signed [OUT_W-1:0] acc;
    logic [TW-1:0]           tap;
    logic signed [OUT_W-1:0] m_out_q;
    logic                    m_valid_q;
    logic                    coef_err_q;

    logic signed [PW-1:0]    product;
    logic signed [OUT_W-1:0] acc_next;
    logic                    last_tap;
    logic                    coef_addr_ok;

    // Handshake strobes are combinational so a sample is taken on the edge it is offered.
    assign bus.s_ready = (state == IDLE) & ena & ~rst;
    assign shift       = bus.s_valid & bus.s_ready;
    assign busy        = (state != IDLE) & ~rst;

    assign bus.m_valid  = m_valid_q;
    assign bus.m_out    = m_out_q;
    assign bus.coef_err = coef_err_q;

    // Shared multiplier; operands widened first so the product keeps full precision.
    always_comb begin
        product      = PW'(hist[tap]) * PW'(coef[tap]);
        acc_next     = acc + OUT_W'(product);
        last_tap     = (tap == TW'(N_TAPS - 1));
        coef_addr_ok = (32'(bus.coef_addr) < N_TAPS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            tap        <= '0;
            m_out_q    <= '0;
            m_valid_q  <= 1'b0;
            coef_err_q <= 1'b0;
            for (int unsigned i = 0; i < N_TAPS; i++) begin
                hist[i] <= '0;
                coef[i] <= '0;
            end
        end else if (ena) begin
            coef_err_q <= 1'b0;

            // Coefficients are frozen while the MAC walk is reading them.
            if (bus.coef_we) begin
                if (state == MAC) begin
                    coef_err_q <= 1'b1;
                end else if (coef_addr_ok) begin
                    coef[bus.coef_addr] <= bus.coef_data;
                end
            end

            case (state)
                IDLE: begin
                    if (bus.s_valid) begin
                        hist[0] <= bus.s_sample;
                        for (int unsigned i = 1; i < N_TAPS; i++) begin
                            hist[i] <= hist[i-1];
                        end
                        acc   <= '0;
                        tap   <= '0;
                        state <= MAC;
                    end
                end

                MAC: begin
                    acc <= acc_next;
                    tap <= tap + TW'(1);
                    if (last_tap) begin
                        m_out_q   <= acc_next;
                        m_valid_q <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: a reference dot-product model feeds a scoreboard
// queue at sample accept; results are popped and compared on each output handshake.
module tb_fir_mac_sequencer;
    localparam int unsigned N      = 16;
    localparam int unsigned N_TAPS = 4;
    localparam int unsigned TW     = $clog2(N_TAPS);
    localparam int unsigned OUT_W  = 2 * N + TW;

    logic clk;
    logic rst;
    logic ena;
    logic shift;
    logic busy;

    fir_mac_sequencer_if #(.N(N), .N_TAPS(N_TAPS)) bus ();

    fir_mac_sequencer #(.N(N), .N_TAPS(N_TAPS)) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .bus   (bus),
        .shift (shift),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_checks  = 0;
    int     n_fail    = 0;
    int     shift_cnt = 0;
    longint last_out  = 0;
    longint sb_q [$];
    longint mhist [N_TAPS];
    longint mcoef [N_TAPS];

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every accepted result.
    always @(negedge clk) begin
        if (shift) shift_cnt++;
        if (!rst && ena && bus.m_valid && bus.m_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_nonempty", 0, 1);
            end else begin
                check_eq("m_out", longint'(bus.m_out), sb_q.pop_front());
                last_out = longint'(bus.m_out);
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < N_TAPS; i++) begin
            mhist[i] = 0;
            mcoef[i] = 0;
        end
        sb_q.delete();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    // Caller guarantees the engine is in IDLE or DONE.
    task automatic write_coef(input int addr, input logic signed [N-1:0] data);
        bus.coef_we   = 1'b1;
        bus.coef_addr = TW'(addr);
        bus.coef_data = data;
        @(posedge clk); #1;
        bus.coef_we = 1'b0;
        mcoef[addr] = longint'(data);
        check_eq("coef_err_idle", longint'(bus.coef_err), 0);
    endtask

    // Offers a sample until shift is seen, then pushes the model result; returns at accept edge +1.
    task automatic send(input logic signed [N-1:0] smp);
        bit     ok;
        longint exp;
        ok           = 1'b0;
        bus.s_valid  = 1'b1;
        bus.s_sample = smp;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (shift) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("accept", longint'(ok), 1);
        if (ok) begin
            for (int i = N_TAPS - 1; i > 0; i--) mhist[i] = mhist[i-1];
            mhist[0] = longint'(smp);
            exp = 0;
            for (int i = 0; i < N_TAPS; i++) exp += mhist[i] * mcoef[i];
            sb_q.push_back(exp);
        end
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (sb_q.size() == 0) break;
        end
        check_eq("drain", longint'(sb_q.size()), 0);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [OUT_W-1:0] held;
        bit seen;
        int sc;

        rst           = 1'b1;
        ena           = 1'b1;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        bus.s_valid   = 1'b0;
        bus.s_sample  = '0;
        bus.m_ready   = 1'b1;
        model_clear();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_s_ready", longint'(bus.s_ready), 0);
        check_eq("rst_busy", longint'(busy), 0);
        check_eq("rst_m_valid", longint'(bus.m_valid), 0);
        check_eq("rst_m_out", longint'(bus.m_out), 0);
        check_eq("rst_coef_err", longint'(bus.coef_err), 0);
        bus.s_valid = 1'b1;
        #1;
        check_eq("rst_shift", longint'(shift), 0);
        bus.s_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("idle_s_ready", longint'(bus.s_ready), 1);
        @(posedge clk); #1;

        // 1: single sample, latency and one shift pulse
        reset_dut();
        for (int i = 0; i < N_TAPS; i++) write_coef(i, N'(i + 1));
        sc = shift_cnt;
        send(16'sd10);
        for (int i = 1; i <= N_TAPS; i++) begin
            @(negedge clk);
            check_eq("latency_low", longint'(bus.m_valid), 0);
        end
        @(negedge clk);
        check_eq("latency_high", longint'(bus.m_valid), 1);
        drain();
        check_eq("t1_m_out", last_out, 10);
        check_eq("t1_shift_cnt", longint'(shift_cnt - sc), 1);

        // 2: impulse response
        reset_dut();
        for (int i = 0; i < N_TAPS; i++) write_coef(i, N'(i + 1));
        for (int i = 0; i < N_TAPS; i++) begin
            send((i == 0) ? 16'sd1 : 16'sd0);
            drain();
            check_eq("impulse", last_out, longint'(i + 1));
        end

        // 3: most-negative operands, full-precision accumulation
        reset_dut();
        for (int i = 0; i < N_TAPS; i++) write_coef(i, -16'sd32768);
        for (int i = 0; i < N_TAPS; i++) send(-16'sd32768);
        drain();
        check_eq("t3_max", last_out, 64'h1_0000_0000);

        // 4: consumer backpressure in DONE
        bus.m_ready = 1'b0;
        send(16'sd123);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.m_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("t4_m_valid_seen", longint'(seen), 1);
        held         = bus.m_out;
        bus.s_valid  = 1'b1;
        bus.s_sample = 16'sd77;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t4_m_valid_hold", longint'(bus.m_valid), 1);
            check_eq("t4_m_out_hold", longint'(bus.m_out), longint'(held));
            check_eq("t4_s_ready", longint'(bus.s_ready), 0);
            check_eq("t4_shift", longint'(shift), 0);
        end
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        drain();

        // 5: coefficient write during MAC is rejected
        send(16'sd3);
        bus.coef_we   = 1'b1;
        bus.coef_addr = '0;
        bus.coef_data = 16'sd7;
        @(posedge clk); #1;
        bus.coef_we = 1'b0;
        check_eq("t5_coef_err_pulse", longint'(bus.coef_err), 1);
        @(posedge clk); #1;
        check_eq("t5_coef_err_clear", longint'(bus.coef_err), 0);
        drain();
        send(16'sd3);
        drain();

        // 5b: coefficient write on the accept edge applies to that sample
        bus.coef_we   = 1'b1;
        bus.coef_addr = TW'(1);
        bus.coef_data = 16'sd5;
        mcoef[1]      = 5;
        send(16'sd2);
        bus.coef_we = 1'b0;
        drain();

        // ena low: everything holds, writes ignored silently
        send(16'sd4);
        ena           = 1'b0;
        bus.coef_we   = 1'b1;
        bus.coef_addr = TW'(2);
        bus.coef_data = 16'sd11;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("ena_coef_err", longint'(bus.coef_err), 0);
            check_eq("ena_s_ready", longint'(bus.s_ready), 0);
            check_eq("ena_busy", longint'(busy), 1);
        end
        ena         = 1'b1;
        bus.coef_we = 1'b0;
        drain();

        // 6: reset mid-MAC clears result, history and coefficients
        send(16'sd9);
        @(posedge clk); #1;
        rst = 1'b1;
        model_clear();
        @(posedge clk); #1;
        check_eq("t6_m_valid", longint'(bus.m_valid), 0);
        check_eq("t6_busy", longint'(busy), 0);
        rst = 1'b0;
        #1;
        check_eq("t6_s_ready", longint'(bus.s_ready), 1);
        send(16'sd5);
        drain();
        check_eq("t6_m_out", last_out, 0);

        // Random coefficients and samples, back to back
        for (int i = 0; i < N_TAPS; i++) write_coef(i, N'($urandom));
        for (int i = 0; i < 10; i++) send(N'($urandom));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
